loctag_scheduler: RTL and testbench

Sequencing controller for the tag's detect-then-reflect cycle. It powers the LT5534 detector, averages NSAMP ADC samples from the serial ADC reader through a req/ack handshake, and on a threshold hit opens a timed reflector window. It sits inside `loctag` between the ADC reader and the reflector modulator, and takes `trig`, `mode` and `force_fs` from the top level.

---
 rtl/loctag_scheduler.sv | 117 +++++++++++
 tb/tb_loctag_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/loctag_scheduler.sv
// loctag_scheduler: powers the detector, averages NSAMP ADC samples and opens a timed
// reflector window on a threshold hit; force_fs overrides everything with a steady reflect.
module loctag_scheduler #(
  parameter int WARMUP_CYC  = 100,
  parameter int NSAMP       = 8,
  parameter int THRESH      = 800,
  parameter int GUARD_CYC   = 50,
  parameter int REFL_CYC    = 5000,
  parameter int HOLDOFF_CYC = 1000,
  parameter int ACK_TMO     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig,
  input  logic        force_fs,
  input  logic [1:0]  mode,
  output logic        det_en,
  output logic        smp_req,
  input  logic        smp_ack,
  input  logic [11:0] smp_data,
  output logic        refl_en,
  output logic        hit,
  output logic        busy,
  output logic        led
);
  localparam int SW = 12 + $clog2(NSAMP);
  localparam logic [SW-1:0] TH_SUM = SW'(THRESH * NSAMP);
  typedef enum logic [2:0] {IDLE, WARM, SAMPLE, DECIDE, GUARD, REFLECT, HOLDOFF} state_t;
  state_t state_q, state_d;
  logic [1:0] trig_s_q, force_s_q, mode_s1_q, mode_s2_q;
  logic trig_prev_q, trig_pe_q;
  logic [15:0] cnt_q, cnt_d, lim;
  logic [6:0] nsmp_q, nsmp_d;
  logic [SW-1:0] sum_q, sum_d;
  logic force_s, ack_ok, cnt_end;
  assign force_s = force_s_q[1];
  assign ack_ok = state_q == SAMPLE && smp_req && smp_ack;
  // In SAMPLE the shared counter measures the current wait for an ack.
  assign lim = state_q == WARM    ? 16'(WARMUP_CYC)  :
               state_q == GUARD   ? 16'(GUARD_CYC)   :
               state_q == REFLECT ? 16'(REFL_CYC)    :
               state_q == HOLDOFF ? 16'(HOLDOFF_CYC) : 16'(ACK_TMO);
  assign cnt_end = cnt_q == lim - 16'd1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 16'd1;
    nsmp_d = nsmp_q;
    sum_d = sum_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if ((mode_s2_q == 2'b01 && trig_pe_q) || mode_s2_q == 2'b10) begin
          state_d = WARM;
          nsmp_d = '0;
          sum_d = '0;
        end else if (mode_s2_q == 2'b11 && trig_pe_q) begin
          state_d = REFLECT;
        end
      end
      WARM:    if (cnt_end) state_d = SAMPLE;
      SAMPLE: begin
        cnt_d = ack_ok ? '0 : cnt_q + {15'd0, smp_req};
        if (ack_ok) begin
          sum_d = sum_q + SW'(smp_data);
          nsmp_d = nsmp_q + 7'd1;
          if (nsmp_q == 7'(NSAMP - 1)) state_d = DECIDE;
        end else if (smp_req && cnt_end) begin
          state_d = HOLDOFF;
        end
      end
      DECIDE:  state_d = sum_q >= TH_SUM ? GUARD : HOLDOFF;
      GUARD:   if (cnt_end) state_d = REFLECT;
      REFLECT: if (cnt_end) state_d = HOLDOFF;
      HOLDOFF: if (cnt_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (force_s) state_d = IDLE;
    if (state_d != state_q) cnt_d = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_s_q <= '0;
      force_s_q <= '0;
      mode_s1_q <= '0;
      mode_s2_q <= '0;
      trig_prev_q <= 1'b0;
      trig_pe_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      nsmp_q <= '0;
      sum_q <= '0;
      det_en <= 1'b0;
      smp_req <= 1'b0;
      refl_en <= 1'b0;
      led <= 1'b0;
      hit <= 1'b0;
      busy <= 1'b0;
    end else begin
      trig_s_q <= {trig_s_q[0], trig};
      force_s_q <= {force_s_q[0], force_fs};
      mode_s1_q <= mode;
      mode_s2_q <= mode_s1_q;
      trig_prev_q <= trig_s_q[1];
      trig_pe_q <= trig_s_q[1] & ~trig_prev_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      nsmp_q <= nsmp_d;
      sum_q <= sum_d;
      det_en <= state_d == WARM || state_d == SAMPLE;
      smp_req <= state_d == SAMPLE && !ack_ok;
      refl_en <= state_d == REFLECT || force_s;
      led <= state_d == REFLECT || force_s;
      hit <= state_d == DECIDE && sum_d >= TH_SUM;
      busy <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_loctag_scheduler.sv
// tb_loctag_scheduler: table-driven and randomized detect/reflect runs checked against
// cycle budgets and mean-threshold decisions derived from the scheduler's documented behaviour.
module tb_loctag_scheduler;
  logic clk = 1'b0, reset = 1'b1, trig = 1'b0, force_fs = 1'b0, smp_ack = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [11:0] smp_data = '0;
  logic det_en, smp_req, refl_en, hit, busy, led;
  int total = 0, bad = 0;
  int n_det = 0, n_req = 0, n_hit = 0, n_refl = 0;
  localparam int S_DET = 0, S_REQ = 1, S_REFL = 2, S_BUSY = 3;

  typedef struct {
    string nm;
    logic [7:0][11:0] d;
    int gmax;
    bit junk;
    bit exp_hit;
  } vec_t;

  always #5 clk = ~clk;

  loctag_scheduler dut (
    .clk(clk), .reset(reset), .trig(trig), .force_fs(force_fs), .mode(mode),
    .det_en(det_en), .smp_req(smp_req), .smp_ack(smp_ack), .smp_data(smp_data),
    .refl_en(refl_en), .hit(hit), .busy(busy), .led(led)
  );

  always @(negedge clk) begin
    n_det <= n_det + int'(det_en);
    n_req <= n_req + int'(smp_req);
    n_hit <= n_hit + int'(hit);
    n_refl <= n_refl + int'(refl_en);
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic sig(input int s);
    return s == S_DET ? det_en : s == S_REQ ? smp_req : s == S_REFL ? refl_en : busy;
  endfunction

  task automatic wait_sig(input string nm, input int s, input logic v, input int lim, output int n);
    n = 0;
    while (sig(s) !== v && n < lim) begin
      tick();
      n++;
    end
    if (sig(s) !== v) begin
      total++;
      bad++;
      $display("FAIL %s: no change within %0d cycles", nm, lim);
    end
  endtask

  task automatic feed(input string nm, input logic [7:0][11:0] d, input int nack, input int gmax, input bit junk);
    int n;
    for (int i = 0; i < nack; i++) begin
      wait_sig({nm, " req"}, S_REQ, 1'b1, 300, n);
      tick($urandom_range(0, gmax));
      smp_ack = 1'b1;
      smp_data = d[i];
      tick();
      smp_ack = 1'b0;
      if (i < 7) begin
        chk1({nm, " req gap"}, smp_req, 1'b0);
        if (junk) begin
          smp_ack = 1'b1;
          smp_data = 12'hfff;
        end
        tick();
        smp_ack = 1'b0;
        chk1({nm, " req again"}, smp_req, 1'b1);
      end
    end
  endtask

  task automatic full_run(input string nm, input logic [7:0][11:0] d, input int gmax, input bit junk, input bit exp_hit);
    int n, h0, r0;
    h0 = n_hit;
    r0 = n_refl;
    trig = 1'b1;
    tick(3);
    chk1({nm, " det_en early"}, det_en, 1'b0);
    tick();
    chk1({nm, " det_en 4cyc"}, det_en, 1'b1);
    trig = 1'b0;
    wait_sig({nm, " sample"}, S_REQ, 1'b1, 200, n);
    chkn({nm, " warm len"}, n, 100);
    chk1({nm, " det_en warm"}, det_en, 1'b1);
    feed(nm, d, 8, gmax, junk);
    chk1({nm, " hit"}, hit, exp_hit);
    chk1({nm, " det_en decide"}, det_en, 1'b0);
    tick();
    chk1({nm, " hit pulse"}, hit, 1'b0);
    if (exp_hit) begin
      wait_sig({nm, " refl on"}, S_REFL, 1'b1, 100, n);
      chkn({nm, " hit->refl"}, n + 1, 51);
      wait_sig({nm, " refl off"}, S_REFL, 1'b0, 6000, n);
      chkn({nm, " refl len"}, n, 5000);
      wait_sig({nm, " idle"}, S_BUSY, 1'b0, 1100, n);
      chkn({nm, " holdoff"}, n, 1000);
    end else begin
      wait_sig({nm, " idle"}, S_BUSY, 1'b0, 1100, n);
      chkn({nm, " decide->idle"}, n + 1, 1001);
    end
    tick();
    chkn({nm, " hit count"}, n_hit - h0, int'(exp_hit));
    chkn({nm, " refl cycles"}, n_refl - r0, exp_hit ? 5000 : 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[5];
    logic [7:0][11:0] rd;
    int n, s, d0, q0;
    tv[0] = '{"all900", {8{12'd900}}, 0, 1'b0, 1'b1};
    tv[1] = '{"sum6400", {8{12'd800}}, 2, 1'b1, 1'b1};
    tv[2] = '{"sum6399", {{7{12'd800}}, 12'd799}, 1, 1'b0, 1'b0};
    tv[3] = '{"max", {8{12'd4095}}, 3, 1'b1, 1'b1};
    tv[4] = '{"zero", {8{12'd0}}, 0, 1'b1, 1'b0};

    tick(3);
    chk1("rst det_en", det_en, 1'b0);
    chk1("rst smp_req", smp_req, 1'b0);
    chk1("rst refl_en", refl_en, 1'b0);
    chk1("rst hit", hit, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst led", led, 1'b0);
    reset = 1'b0;
    mode = 2'b01;
    tick(3);

    for (int i = 0; i < 5; i++) full_run(tv[i].nm, tv[i].d, tv[i].gmax, tv[i].junk, tv[i].exp_hit);

    for (int r = 0; r < 3; r++) begin
      s = 0;
      for (int i = 0; i < 8; i++) begin
        rd[i] = 12'($urandom_range(0, 1599));
        s += int'(rd[i]);
      end
      full_run($sformatf("rand%0d", r), rd, 4, 1'($urandom_range(0, 1)), s >= 800 * 8);
    end

    q0 = n_hit;
    d0 = n_refl;
    trig = 1'b1;
    tick(4);
    trig = 1'b0;
    feed("tmo", {8{12'd900}}, 3, 2, 1'b0);
    wait_sig("tmo req drop", S_REQ, 1'b0, 400, n);
    chkn("tmo wait", n, 255);
    chk1("tmo busy", busy, 1'b1);
    chk1("tmo det_en", det_en, 1'b0);
    tick(100);
    trig = 1'b1;
    tick(3);
    trig = 1'b0;
    wait_sig("tmo idle", S_BUSY, 1'b0, 1100, n);
    chkn("tmo holdoff", n + 103, 1000);
    tick(20);
    chk1("tmo trig dropped", busy, 1'b0);
    chkn("tmo no hit", n_hit - q0, 0);
    chkn("tmo no refl", n_refl - d0, 0);

    mode = 2'b11;
    tick(3);
    d0 = n_det;
    q0 = n_req;
    trig = 1'b1;
    tick(3);
    chk1("m11 refl early", refl_en, 1'b0);
    tick();
    chk1("m11 refl 4cyc", refl_en, 1'b1);
    chk1("m11 led", led, 1'b1);
    trig = 1'b0;
    wait_sig("m11 refl off", S_REFL, 1'b0, 6000, n);
    chkn("m11 refl len", n, 5000);
    wait_sig("m11 idle", S_BUSY, 1'b0, 1100, n);
    chkn("m11 holdoff", n, 1000);
    chkn("m11 no det_en", n_det - d0, 0);
    chkn("m11 no smp_req", n_req - q0, 0);

    mode = 2'b10;
    wait_sig("frc sample", S_REQ, 1'b1, 200, n);
    force_fs = 1'b1;
    tick(3);
    chk1("frc refl_en", refl_en, 1'b1);
    chk1("frc led", led, 1'b1);
    chk1("frc det_en", det_en, 1'b0);
    chk1("frc smp_req", smp_req, 1'b0);
    chk1("frc busy", busy, 1'b0);
    trig = 1'b1;
    tick(5);
    trig = 1'b0;
    tick(5);
    chk1("frc held refl", refl_en, 1'b1);
    chk1("frc held det", det_en, 1'b0);
    force_fs = 1'b0;
    wait_sig("frc resume", S_DET, 1'b1, 4, n);
    chk1("frc released refl", refl_en, 1'b0);

    wait_sig("rst sample", S_REQ, 1'b1, 200, n);
    feed("rstrun", {8{12'd900}}, 8, 1, 1'b0);
    chk1("rstrun hit", hit, 1'b1);
    wait_sig("rstrun refl", S_REFL, 1'b1, 100, n);
    tick(100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("midrst refl_en", refl_en, 1'b0);
    chk1("midrst led", led, 1'b0);
    chk1("midrst busy", busy, 1'b0);
    chk1("midrst det_en", det_en, 1'b0);
    chk1("midrst smp_req", smp_req, 1'b0);
    smp_ack = 1'b1;
    smp_data = 12'hfff;
    tick();
    smp_ack = 1'b0;
    wait_sig("midrst restart", S_DET, 1'b1, 10, n);
    wait_sig("midrst sample", S_REQ, 1'b1, 200, n);
    chkn("midrst warm len", n, 100);
    feed("midrst", {8{12'd800}}, 8, 0, 1'b0);
    chk1("midrst hit", hit, 1'b1);

    mode = 2'b00;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(5);
    chk1("end idle", busy, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
